hd44780_avalon_responder: RTL and testbench

Avalon-MM slave that sits between the UI state machine (the Avalon master) and the HD44780-compatible character LCD pins. It accepts single-beat reads and writes on a 1-bit address space: address 0 is instruction/status, address 1 is character data. Each access is converted into a timed LCD bus cycle (setup, enable pulse, hold, execution wait). `waitrequest` stalls the master until the cycle completes.

---
 rtl/hd44780_avalon_responder_if.sv | 21 ++
 rtl/hd44780_avalon_responder.sv | 169 ++++++++++++++++
 tb/tb_hd44780_avalon_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hd44780_avalon_responder_if.sv
// Avalon-MM slave port bundle for the HD44780 responder.
// The UI state machine holds the master side and the LCD responder holds the slave side.
interface hd44780_avalon_responder_if;
  logic       address;
  logic       chipselect;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/hd44780_avalon_responder.sv
// Converts single-beat Avalon-MM accesses into timed HD44780 bus cycles
// (setup, enable pulse, hold, execution wait), stalling the master meanwhile.
module hd44780_avalon_responder #(
  parameter int unsigned SETUP_CYCLES  = 3,
  parameter int unsigned ENABLE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned EXEC_CYCLES   = 2000,
  parameter int unsigned CLEAR_CYCLES  = 82000
) (
  input  logic                        clk,
  input  logic                        reset,
  hd44780_avalon_responder_if.slave   avs,
  inout  wire  [7:0]                  LCD_DATA,
  output logic                        LCD_ON,
  output logic                        LCD_BLON,
  output logic                        LCD_EN,
  output logic                        LCD_RS,
  output logic                        LCD_RW
);

  localparam int unsigned CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] ENABLE_LD = CW'(ENABLE_CYCLES);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] EXEC_LD   = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD  = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_EXEC   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          en_q, en_d;
  logic          drive_q, drive_d;
  logic          on_q;
  logic          req_s;
  logic          expire_s;
  logic          clear_s;

  assign req_s    = avs.chipselect & (avs.read | avs.write);
  // A phase loaded with C lasts C cycles; counts of 0 or 1 both expire at once.
  assign expire_s = (cnt_q <= CNT_ONE);
  assign clear_s  = ~rs_q & ((wdata_q == 8'h01) | (wdata_q == 8'h02) | (wdata_q == 8'h03));

  // Next-state, counter and latch logic of the LCD bus cycle sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          rs_d    = avs.address;
          rw_d    = ~avs.write;
          wdata_d = avs.writedata;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (expire_s) begin
          cnt_d   = ENABLE_LD;
          state_d = S_ENABLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ENABLE: begin
        if (expire_s) begin
          if (rw_q) begin
            rdata_d = LCD_DATA;
          end else begin
            rdata_d = rdata_q;
          end
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (expire_s) begin
          if (rw_q) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = clear_s ? CLEAR_LD : EXEC_LD;
            state_d = S_EXEC;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_EXEC: begin
        if (expire_s) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin controls are derived from the next state so they change together with it.
  always_comb begin
    en_d    = (state_d == S_ENABLE);
    drive_d = ~rw_d & ((state_d == S_SETUP) | (state_d == S_ENABLE) | (state_d == S_HOLD));
  end

  // State, datapath and registered pin outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      en_q    <= 1'b0;
      drive_q <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      drive_q <= drive_d;
      on_q    <= 1'b1;
    end
  end

  // waitrequest must rise in the very cycle a request appears, so it stays combinational.
  assign avs.waitrequest = reset | (req_s & (state_q != S_DONE));
  assign avs.readdata    = rdata_q;
  assign LCD_DATA        = drive_q ? wdata_q : 8'hzz;
  assign LCD_EN          = en_q;
  assign LCD_RS          = rs_q;
  assign LCD_RW          = rw_q;
  assign LCD_ON          = on_q;
  assign LCD_BLON        = on_q;

endmodule

// File: tb/tb_hd44780_avalon_responder.sv
// Directed bench: a window-arithmetic model of the LCD bus cycle checks every cycle,
// and each access also checks hand-computed latency, pulse width and drive counts.
module tb_hd44780_avalon_responder;
  localparam int S = 3;
  localparam int E = 16;
  localparam int H = 2;
  localparam int X = 40;
  localparam int C = 300;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_val = 8'h80;
  logic       rst_at_edge = 1'b0;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  wire  [7:0] lcd_data;
  logic       lcd_on, lcd_blon, lcd_en, lcd_rs, lcd_rw;

  hd44780_avalon_responder_if avs_if ();

  hd44780_avalon_responder #(
    .SETUP_CYCLES (S),
    .ENABLE_CYCLES(E),
    .HOLD_CYCLES  (H),
    .EXEC_CYCLES  (X),
    .CLEAR_CYCLES (C)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .avs     (avs_if),
    .LCD_DATA(lcd_data),
    .LCD_ON  (lcd_on),
    .LCD_BLON(lcd_blon),
    .LCD_EN  (lcd_en),
    .LCD_RS  (lcd_rs),
    .LCD_RW  (lcd_rw)
  );

  // An undriven bus reads 0xFF; the LCD side answers reads only while EN is high.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (lcd_data[g]);
  end
  assign lcd_data = (tb_drv && lcd_en) ? tb_val : 8'hzz;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_at_edge <= reset;
    cyc         <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: an access seen in an idle cycle t0 follows fixed windows of offset k = cyc - t0.
  initial begin : model
    bit         active, a_wr, a_addr, rs_e, rw_e, en_e, wr_e, req;
    logic [7:0] a_data, rd_e, bus_e;
    int         t0, n, k;
    active = 1'b0; a_wr = 1'b0; a_addr = 1'b0; rs_e = 1'b0; rw_e = 1'b0;
    a_data = 8'h00; rd_e = 8'h00; t0 = 0; n = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      req = avs_if.chipselect && (avs_if.read || avs_if.write);
      if (rst_at_edge) begin
        active = 1'b0; rs_e = 1'b0; rw_e = 1'b0; rd_e = 8'h00;
      end
      if (!active && req && !reset) begin
        active = 1'b1;
        t0     = cyc;
        a_wr   = avs_if.write;
        a_addr = avs_if.address;
        a_data = avs_if.writedata;
        if (!a_wr) n = 1 + S + E + H;
        else if (!a_addr && (a_data inside {8'h01, 8'h02, 8'h03})) n = 1 + S + E + H + C;
        else n = 1 + S + E + H + X;
      end
      k = active ? (cyc - t0) : 0;
      if (active && k == 1) begin
        rs_e = a_addr;
        rw_e = !a_wr;
      end
      en_e = active && (k >= 1 + S) && (k <= S + E);
      if (active && a_wr && k >= 1 && k <= S + E + H) bus_e = a_data;
      else if (active && !a_wr && en_e && tb_drv) bus_e = tb_val;
      else bus_e = 8'hff;
      wr_e = reset || (req && !(active && k == n));
      chk("LCD_EN", int'(lcd_en), int'(en_e));
      chk("LCD_RS", int'(lcd_rs), int'(rs_e));
      chk("LCD_RW", int'(lcd_rw), int'(rw_e));
      chk("LCD_DATA", int'(lcd_data), int'(bus_e));
      chk("LCD_ON", int'(lcd_on), int'(!rst_at_edge));
      chk("LCD_BLON", int'(lcd_blon), int'(!rst_at_edge));
      chk("waitrequest", int'(avs_if.waitrequest), int'(wr_e));
      if (active && k == n && !a_wr) rd_e = tb_drv ? tb_val : 8'hff;
      if (!(active && !a_wr && k < n)) chk("readdata", int'(avs_if.readdata), int'(rd_e));
      if (active && k == n) active = 1'b0;
    end
  end

  task automatic wait_accept(output int lat, output int en_n, output int drv_n);
    lat = -1; en_n = 0; drv_n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (lcd_en) en_n++;
      if (lcd_data != 8'hff) drv_n++;
      if (!avs_if.waitrequest) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic access(input logic w, input logic r, input logic a, input logic [7:0] d,
                        input int exp_lat, input int exp_drv, input string name);
    int lat, en_n, drv_n;
    @(posedge clk); #2;
    avs_if.chipselect = 1'b1;
    avs_if.write      = w;
    avs_if.read       = r;
    avs_if.address    = a;
    avs_if.writedata  = d;
    wait_accept(lat, en_n, drv_n);
    @(posedge clk); #2;
    avs_if.chipselect = 1'b0;
    avs_if.write      = 1'b0;
    avs_if.read       = 1'b0;
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_en_width"}, en_n, 16);
    chk({name, "_bus_cycles"}, drv_n, exp_drv);
  endtask

  initial begin : stim
    int lat, en_n, drv_n;
    avs_if.chipselect = 1'b0;
    avs_if.write      = 1'b0;
    avs_if.read       = 1'b0;
    avs_if.address    = 1'b0;
    avs_if.writedata  = 8'h00;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_waitrequest", int'(avs_if.waitrequest), 0);
    chk("idle_lcd_on", int'(lcd_on), 1);
    chk("idle_readdata", int'(avs_if.readdata), 8'h00);

    access(1'b1, 1'b0, 1'b1, 8'h41, 62, 21, "wr_data_41");
    access(1'b1, 1'b0, 1'b0, 8'h01, 322, 21, "wr_clear_01");
    access(1'b1, 1'b0, 1'b0, 8'h38, 62, 21, "wr_func_38");
    access(1'b1, 1'b0, 1'b0, 8'h03, 322, 21, "wr_home_03");
    access(1'b1, 1'b0, 1'b1, 8'h02, 62, 21, "wr_data_02");

    tb_drv = 1'b1;
    access(1'b0, 1'b1, 1'b0, 8'h00, 22, 16, "rd_status");
    tb_drv = 1'b0;
    chk("rd_status_value", int'(avs_if.readdata), 8'h80);

    access(1'b1, 1'b1, 1'b1, 8'h5A, 62, 21, "rdwr_5A");
    chk("rdwr_readdata_kept", int'(avs_if.readdata), 8'h80);

    // Reset lands mid-access; the held request must replay in full afterwards.
    @(posedge clk); #2;
    avs_if.chipselect = 1'b1;
    avs_if.write      = 1'b1;
    avs_if.address    = 1'b1;
    avs_if.writedata  = 8'h41;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_en", int'(lcd_en), 0);
    chk("midrst_bus", int'(lcd_data), 8'hff);
    chk("midrst_waitrequest", int'(avs_if.waitrequest), 1);
    @(posedge clk); #2 reset = 1'b0;
    wait_accept(lat, en_n, drv_n);
    @(posedge clk); #2;
    avs_if.chipselect = 1'b0;
    avs_if.write      = 1'b0;
    chk("midrst_replay_latency", lat, 62);
    chk("midrst_replay_en_width", en_n, 16);
    chk("midrst_readdata", int'(avs_if.readdata), 8'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
